// File: rtl/ram_pkg.sv
// Shared state encoding, default geometry/latency and error read pattern for the RAM responder.
package ram_pkg;

  typedef enum logic {
    S_READY = 1'b0,
    S_BUSY  = 1'b1
  } ram_state_e;

  localparam int          RAM_DEF_ADDR_WIDTH = 10;
  localparam int          RAM_DEF_LATENCY    = 4;
  localparam logic [31:0] RAM_ERR_RDATA      = 32'h0000_0000;

endpackage

// File: rtl/ram_array.sv
// Single-port 2^ADDR_WIDTH x 32 storage, synchronous write, registered read data.
// One cycle from re_i to rdata_o; no backpressure, the caller strobes only on access completion.
module ram_array
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] rdata_q;

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Backing memory for the cache RAM port: one word per request, completing LATENCY cycles after acceptance.
// ack low while busy (requests then dropped, not queued); RAM_ERR_EN adds the err out-of-range flag.
module ram_responder
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_DEF_ADDR_WIDTH,
  parameter int LATENCY    = RAM_DEF_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] din_i,
  output logic [31:0] dout_o,
  output logic        ack_o
`ifdef RAM_ERR_EN
  ,
  output logic        err_o
`endif
);

  ram_state_e            state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic                  oor_q;
  logic                  ack_q;
  logic                  err_q;
  logic                  rd_err_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           din_q;
  logic [31:0]           arr_rdata;
  logic                  oor_d;
  logic                  done_d;
  logic                  arr_we_d;
  logic                  arr_re_d;

`ifdef RAM_ERR_EN
  logic unused_addr;
  assign oor_d       = |addr_i[31:ADDR_WIDTH+2];
  assign err_o       = err_q;
  assign unused_addr = ^addr_i[1:0];
`else
  // Upper address bits are dropped, so addresses wrap within the array.
  logic unused_bits;
  assign oor_d       = 1'b0;
  assign unused_bits = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0], err_q};
`endif

  // Completion strobes are gated by rst_i so a reset on the final busy edge commits nothing.
  assign done_d   = (state_q == S_BUSY) && (cnt_q == 4'd0) && !rst_i;
  assign arr_we_d = done_d && we_q && !oor_q;
  assign arr_re_d = done_d && !we_q && !oor_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_READY;
      cnt_q    <= 4'd0;
      ack_q    <= 1'b1;
      err_q    <= 1'b0;
      rd_err_q <= 1'b0;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      idx_q    <= '0;
      din_q    <= '0;
    end else begin
      case (state_q)
        S_READY: begin
          if (cs_i) begin
            we_q    <= we_i;
            idx_q   <= addr_i[ADDR_WIDTH+1:2];
            din_q   <= din_i;
            oor_q   <= oor_d;
            cnt_q   <= 4'(LATENCY - 1);
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ack_q   <= 1'b1;
            err_q   <= oor_q;
            state_q <= S_READY;
            if (!we_q) begin
              rd_err_q <= oor_q;
            end
          end
        end
        default: state_q <= S_READY;
      endcase
    end
  end

  ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (arr_we_d),
    .re_i   (arr_re_d),
    .idx_i  (idx_q),
    .wdata_i(din_q),
    .rdata_o(arr_rdata)
  );

  assign dout_o = rd_err_q ? RAM_ERR_RDATA : arr_rdata;
  assign ack_o  = ack_q;

endmodule

// File: tb/tb_ram_responder.sv
// Randomized self-checking bench for ram_responder against a word-array reference model.
module tb_ram_responder;

  localparam int AW  = 10;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ack;
`ifdef RAM_ERR_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl [int];
  logic [31:0] bw [4];
  logic [31:0] br [4];

  always #5 clk = ~clk;

  ram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .cs_i  (cs),
    .we_i  (we),
    .addr_i(addr),
    .din_i (din),
    .dout_o(dout),
    .ack_o (ack)
`ifdef RAM_ERR_EN
    ,
    .err_o (err)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic logic is_oor(input logic [31:0] a);
`ifdef RAM_ERR_EN
    return a[31:AW+2] != '0;
`else
    return 1'b0;
`endif
  endfunction

  // Single request: returns edges from acceptance until ack is seen high, plus dout/err then.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic e);
    @(negedge clk);
    cs = 1'b1; we = w; addr = a; din = d;
    @(posedge clk); #1;
    cs = 1'b0; we = $urandom_range(0, 1); addr = $urandom; din = $urandom;
    lat = 0;
    while (ack !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = dout;
`ifdef RAM_ERR_EN
    e = err;
`else
    e = 1'b0;
`endif
  endtask

  // Four back-to-back requests with cs held; edges counted from the first acceptance edge.
  task automatic burst(input logic w, input logic [31:0] base, output int edges);
    int   acc;
    int   done;
    logic prev;
    acc = 0; done = 0; prev = 1'b1; edges = 0;
    @(negedge clk);
    cs = 1'b1; we = w; addr = base; din = bw[0];
    while (done < 4 && edges < 200) begin
      @(posedge clk); edges++; #1;
      if (prev && !ack) begin
        acc++;
        if (acc < 4) begin
          addr = base + 32'(4 * acc);
          din  = bw[acc];
        end else begin
          cs = 1'b0;
        end
      end else if (!prev && ack) begin
        br[done] = dout;
        done++;
      end
      prev = ack;
    end
    cs = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack: got %b want 1", ack); end
    n_checks++;
    if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
`ifdef RAM_ERR_EN
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); we = $urandom_range(0, 1); addr = $urandom; din = $urandom;
      @(posedge clk); #1;
      n_checks++;
      if (ack !== 1'b1 || dout !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: ack=%b dout=%h want ack=1 dout=0", i, ack, dout);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic e;
    xfer(1'b1, 32'h40, 32'hCAFEF00D, lat, rd, e);
    mdl[widx(32'h40)] = 32'hCAFEF00D;
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_dout_unchanged: got %h want 0", rd); end
    xfer(1'b0, 32'h40, 32'h0, lat, rd, e);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT); end
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_data: got %h want cafef00d", rd); end
`ifdef RAM_ERR_EN
    n_checks++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", e); end
`endif
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b1 || dout !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL rd_hold: ack=%b dout=%h want ack=1 dout=cafef00d", ack, dout);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    for (int i = 0; i < 4; i++) bw[i] = $urandom;
    burst(1'b1, 32'h100, edges);
    for (int i = 0; i < 4; i++) mdl[widx(32'h100 + 32'(4 * i))] = bw[i];
    n_checks++;
    if (edges !== 4 * (LAT + 1)) begin n_fail++; $display("FAIL burst_wr_cycles: got %0d want %0d", edges, 4 * (LAT + 1)); end
    burst(1'b0, 32'h100, edges);
    n_checks++;
    if (edges !== 4 * (LAT + 1)) begin n_fail++; $display("FAIL burst_rd_cycles: got %0d want %0d", edges, 4 * (LAT + 1)); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (br[i] !== mdl[widx(32'h100 + 32'(4 * i))]) begin
        n_fail++;
        $display("FAIL burst_rd_data[%0d]: got %h want %h", i, br[i], mdl[widx(32'h100 + 32'(4 * i))]);
      end
    end
  endtask

  task automatic test_dropped();
    int lat; logic [31:0] rd; logic e; logic [31:0] a_val; logic [31:0] c_val;
    a_val = $urandom; c_val = $urandom;
    xfer(1'b1, 32'h80, a_val, lat, rd, e);
    mdl[widx(32'h80)] = a_val;
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = 32'h84; din = c_val;
    @(posedge clk); #1; cs = 1'b0;
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = 32'h80; din = ~a_val;
    @(negedge clk); cs = 1'b0;
    lat = 0;
    while (ack !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
    mdl[widx(32'h84)] = c_val;
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL drop_not_queued: ack=%b want 1", ack); end
    xfer(1'b0, 32'h80, 32'h0, lat, rd, e);
    n_checks++;
    if (rd !== a_val) begin n_fail++; $display("FAIL drop_word80: got %h want %h", rd, a_val); end
    xfer(1'b0, 32'h84, 32'h0, lat, rd, e);
    n_checks++;
    if (rd !== c_val) begin n_fail++; $display("FAIL drop_word84: got %h want %h", rd, c_val); end
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [31:0] rd; logic e; logic [31:0] old_val;
    old_val = $urandom;
    xfer(1'b1, 32'h200, old_val, lat, rd, e);
    mdl[widx(32'h200)] = old_val;
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = 32'h200; din = ~old_val;
    @(posedge clk); #1; cs = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b1 || dout !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_state: ack=%b dout=%h want ack=1 dout=0", ack, dout);
    end
    @(negedge clk); rst = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL midrst_idle: ack=%b want 1", ack); end
    xfer(1'b0, 32'h200, 32'h0, lat, rd, e);
    n_checks++;
    if (rd !== old_val) begin n_fail++; $display("FAIL midrst_word: got %h want %h", rd, old_val); end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic e; logic [31:0] v0; logic [31:0] v1;
    v0 = $urandom; v1 = $urandom;
    xfer(1'b1, 32'h0, v0, lat, rd, e);
    mdl[0] = v0;
    xfer(1'b1, 32'h0000_1000, v1, lat, rd, e);
`ifdef RAM_ERR_EN
    n_checks++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b want 1", e); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err_hold: got %b want 1", err); end
    xfer(1'b0, 32'h0000_1000, 32'h0, lat, rd, e);
    n_checks++;
    if (rd !== 32'h0 || e !== 1'b1 || lat !== LAT) begin
      n_fail++;
      $display("FAIL oor_rd: dout=%h err=%b lat=%0d want 0/1/%0d", rd, e, lat, LAT);
    end
`else
    mdl[0] = v1;
`endif
    xfer(1'b0, 32'h0, 32'h0, lat, rd, e);
    n_checks++;
    if (rd !== mdl[0]) begin n_fail++; $display("FAIL range_word0: got %h want %h", rd, mdl[0]); end
`ifdef RAM_ERR_EN
    n_checks++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL inrange_err_clear: got %b want 0", e); end
`endif
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic e; logic w; logic [31:0] a; logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'h300 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a[31:AW+2] = 20'($urandom_range(1, 20'hFFFFF));
      d = $urandom;
      if (!w && !is_oor(a) && !mdl.exists(widx(a))) w = 1'b1;
      xfer(w, a, d, lat, rd, e);
      n_checks++;
      if (lat !== LAT) begin n_fail++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, LAT); end
`ifdef RAM_ERR_EN
      n_checks++;
      if (e !== is_oor(a)) begin n_fail++; $display("FAIL rand_err[%0d]: got %b want %b", i, e, is_oor(a)); end
`endif
      if (w) begin
        if (!is_oor(a)) mdl[widx(a)] = d;
      end else begin
        n_checks++;
        if (is_oor(a)) begin
          if (rd !== 32'h0) begin n_fail++; $display("FAIL rand_oor_rd[%0d]: got %h want 0", i, rd); end
        end else if (rd !== mdl[widx(a)]) begin
          n_fail++;
          $display("FAIL rand_rd[%0d] addr %h: got %h want %h", i, a, rd, mdl[widx(a)]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_dropped();
    test_reset_mid_access();
    test_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
